noc_merge_arbiter: RTL and testbench
====================================

# noc_merge_arbiter

Sequential arbiter that drains NUM_SRC parallel clause-result FIFOs into the single shared FIFO feeding the PE threads. It picks one non-empty source, reads one 36-bit packet with a read_req/read_gnt handshake, holds it, and writes it downstream with a write_req/write_gnt handshake. It sits between the table_test output FIFO bank and the last-stage FIFO, and provides a transferred-packet counter for debug.

## Interface
- NUM_SRC, 20, number of source FIFOs (2..32)
- PKT_W, 36, packet width in bits
- IDX_W, 5, source index width; must satisfy 2**IDX_W >= NUM_SRC
- CNT_W, 16, transferred-packet counter width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- src_empty  input  NUM_SRC  bit i high = source FIFO i empty
- src_read_req  output  NUM_SRC  one-hot read request to source i
- src_read_gnt  input  NUM_SRC  source i read grant; packet valid in grant cycle
- src_packet  input  NUM_SRC*PKT_W  flattened source packets, source i at [i*PKT_W +: PKT_W]
- sink_full  input  1  downstream FIFO full
- sink_write_req  output  1  write request to downstream FIFO
- sink_write_gnt  input  1  downstream write grant, one-cycle pulse
- sink_packet  output  PKT_W  packet presented with sink_write_req
- cur_src  output  IDX_W  index of source being served
- busy  output  1  high in any state other than IDLE
- pkt_count  output  CNT_W  number of completed sink writes

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE: if any src_empty bit is low and sink_full is low, select a source, latch it into cur_src, raise src_read_req[cur_src], go to READ. Otherwise stay. All outputs are deasserted.
- READ: hold src_read_req[cur_src] until src_read_gnt[cur_src]. In the grant cycle, capture src_packet slice into the holding register, drop src_read_req, go to WRITE. Grants on other bits are ignored.
- WRITE: drive sink_write_req=1 with sink_packet = holding register until sink_write_gnt. In the grant cycle, drop the request, increment pkt_count, update the arbitration pointer, go to IDLE.
- sink_full is sampled only in IDLE. A packet already read is always held until it is written, never dropped.
- src_read_req is one-hot or zero and is never high outside READ.
- pkt_count wraps modulo 2**CNT_W.
- Reset (any state, asynchronous): state=IDLE, src_read_req=0, sink_write_req=0, sink_packet=0, cur_src=0, busy=0, pkt_count=0, pointer=NUM_SRC-1. A packet in flight at reset is lost.

## Timing
- Decision is registered. src_read_req rises one cycle after the IDLE cycle that sees a non-empty source.
- If the grant is immediate, the minimum transfer is 3 cycles: IDLE, READ with grant, WRITE with grant. Peak throughput is one packet per 3 cycles.
- Each extra grant-wait cycle in READ or WRITE adds one cycle. There is no timeout.
- Selection uses the src_empty value in the IDLE cycle. A source that empties later is still requested, and the arbiter waits for its grant.
- The pointer update takes effect in the next IDLE decision.

## Configuration
- NOC_ARB_ROUND_ROBIN_EN defined: round-robin. The search starts at (pointer+1) mod NUM_SRC and takes the first non-empty source. After each completed write, pointer = cur_src.
- Not defined: fixed priority. The lowest-index non-empty source always wins, and the pointer register is not built.

## Test plan
- Reset check: pulse rst low mid-WRITE with sink_write_req=1 -> sink_write_req, src_read_req and pkt_count are 0 immediately, busy=0, and the FSM restarts from IDLE.
- Single transfer: source 3 non-empty with packet 36'h0_DEAD_BEEF, grants immediate -> src_read_req=20'h00008 for 1 cycle, then sink_write_req=1 with sink_packet=36'h0_DEAD_BEEF, pkt_count=1, 3 cycles total.
- Round-robin (macro on): sources 0, 5 and 19 all non-empty, each with 2 packets -> service order 0, 5, 19, 0, 5, 19 and pkt_count=6. Macro off -> order 0, 0, 5, 5, 19, 19.
- Backpressure: sink_full=1 while sources are non-empty -> src_read_req stays 0. Separately, delay sink_write_gnt 4 cycles -> sink_packet stays stable and no new src_read_req is issued.
- Delayed source grant: src_read_gnt[7] arrives 5 cycles late, and a spurious src_read_gnt[2] pulse occurs meanwhile -> only the source 7 packet is written and the spurious grant is ignored.
- Counter wrap: CNT_W=4, 17 transfers -> pkt_count=1.

Source files
------------

// File: rtl/noc_merge_arbiter.sv
// noc_merge_arbiter
//
// Drains NUM_SRC parallel clause-result FIFOs into the single shared FIFO that
// feeds the PE threads. One packet is moved per transaction:
//   IDLE  -> pick a non-empty source (only while the sink is not full)
//   READ  -> src_read_req[cur_src] held until src_read_gnt[cur_src]; capture packet
//   WRITE -> sink_write_req held with the captured packet until sink_write_gnt
//
// Build option:
//   NOC_ARB_ROUND_ROBIN_EN  defined   : round-robin, search starts after the
//                                       last-served source
//                           undefined : fixed priority, lowest index wins
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   src_empty      per-source empty flags
//   src_read_req   one-hot read request (only in READ)
//   src_read_gnt   per-source read grant, packet valid in the grant cycle
//   src_packet     flattened source packets, source i at [i*PKT_W +: PKT_W]
//   sink_full      downstream full, sampled only in IDLE
//   sink_write_req write request to downstream
//   sink_write_gnt downstream write grant (one-cycle pulse)
//   sink_packet    packet presented with sink_write_req
//   cur_src        index of source being served
//   busy           high whenever the FSM is not in IDLE
//   pkt_count      completed sink writes, wraps modulo 2**CNT_W

module noc_merge_arbiter #(
  parameter int unsigned NUM_SRC = 20,
  parameter int unsigned PKT_W   = 36,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_empty,
  output logic [NUM_SRC-1:0]       src_read_req,
  input  logic [NUM_SRC-1:0]       src_read_gnt,
  input  logic [NUM_SRC*PKT_W-1:0] src_packet,
  input  logic                     sink_full,
  output logic                     sink_write_req,
  input  logic                     sink_write_gnt,
  output logic [PKT_W-1:0]         sink_packet,
  output logic [IDX_W-1:0]         cur_src,
  output logic                     busy,
  output logic [CNT_W-1:0]         pkt_count
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] src_read_req_q;
  logic               sink_write_req_q;
  logic [PKT_W-1:0]   sink_packet_q;
  logic [IDX_W-1:0]   cur_src_q;
  logic               busy_q;
  logic [CNT_W-1:0]   pkt_count_q;

  // Arbitration result for the current IDLE cycle
  logic               any_avail;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_SRC-1:0] sel_onehot;

  // Grant and packet of the source currently being served
  logic               rd_gnt;
  logic [PKT_W-1:0]   rd_pkt;

`ifdef NOC_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // First non-empty source at or after ptr+1, wrapping at NUM_SRC
  always_comb begin
    any_avail = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand     = (32'(ptr_q) + 32'd1 + k) % NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!any_avail && !src_empty[cand_idx]) begin
        any_avail = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end
`else
  // Lowest-index non-empty source wins
  always_comb begin
    any_avail = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!any_avail && !src_empty[k]) begin
        any_avail = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    sel_onehot = '0;
    rd_gnt     = 1'b0;
    rd_pkt     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      sel_onehot[k] = (sel_idx == IDX_W'(k));
      // Only the served source's grant matters; grants on other bits are ignored
      if (cur_src_q == IDX_W'(k)) begin
        rd_gnt = src_read_gnt[k];
        rd_pkt = src_packet[k*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      src_read_req_q   <= '0;
      sink_write_req_q <= 1'b0;
      sink_packet_q    <= '0;
      cur_src_q        <= '0;
      busy_q           <= 1'b0;
      pkt_count_q      <= '0;
`ifdef NOC_ARB_ROUND_ROBIN_EN
      ptr_q            <= IDX_W'(NUM_SRC - 1);
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (any_avail && !sink_full) begin
            cur_src_q      <= sel_idx;
            src_read_req_q <= sel_onehot;
            busy_q         <= 1'b1;
            state_q        <= StRead;
          end
        end
        StRead: begin
          if (rd_gnt) begin
            sink_packet_q    <= rd_pkt;
            src_read_req_q   <= '0;
            sink_write_req_q <= 1'b1;
            state_q          <= StWrite;
          end
        end
        StWrite: begin
          // Packet is held here until written; sink_full is not consulted
          if (sink_write_gnt) begin
            sink_write_req_q <= 1'b0;
            pkt_count_q      <= pkt_count_q + CNT_W'(1);
            busy_q           <= 1'b0;
            state_q          <= StIdle;
`ifdef NOC_ARB_ROUND_ROBIN_EN
            ptr_q            <= cur_src_q;
`endif
          end
        end
        default: begin
          src_read_req_q   <= '0;
          sink_write_req_q <= 1'b0;
          busy_q           <= 1'b0;
          state_q          <= StIdle;
        end
      endcase
    end
  end

  assign src_read_req   = src_read_req_q;
  assign sink_write_req = sink_write_req_q;
  assign sink_packet    = sink_packet_q;
  assign cur_src        = cur_src_q;
  assign busy           = busy_q;
  assign pkt_count      = pkt_count_q;

endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Testbench for noc_merge_arbiter. Sources and sink are modelled by the bench;
// expected packets are queued in the predicted service order when stimulus is
// loaded and compared when the DUT presents them to the sink.

module tb_noc_merge_arbiter;

  localparam int NS = 20;
  localparam int PW = 36;
  localparam int IW = 5;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_empty;
  logic [NS-1:0]    src_read_req;
  logic [NS-1:0]    src_read_gnt;
  logic [NS*PW-1:0] src_packet;
  logic             sink_full;
  logic             sink_write_req;
  logic             sink_write_gnt;
  logic [PW-1:0]    sink_packet;
  logic [IW-1:0]    cur_src;
  logic             busy;
  logic [CW-1:0]    pkt_count;

  always #5 clk = ~clk;

  noc_merge_arbiter #(
    .NUM_SRC(NS),
    .PKT_W  (PW),
    .IDX_W  (IW),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .src_empty     (src_empty),
    .src_read_req  (src_read_req),
    .src_read_gnt  (src_read_gnt),
    .src_packet    (src_packet),
    .sink_full     (sink_full),
    .sink_write_req(sink_write_req),
    .sink_write_gnt(sink_write_gnt),
    .sink_packet   (sink_packet),
    .cur_src       (cur_src),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Source FIFO contents
  logic [PW-1:0] data [NS][32];
  int            head [NS];
  int            tail [NS];

  logic [PW-1:0] exp_q [$];
  int            model_cnt = 0;
  int            rd_delay = 0, wr_delay = 0, rd_wait = 0, wr_wait = 0;
  int            rd_hi = 0, wr_hi = 0;
  bit            spur = 1'b0;

  task automatic load(input int s, input logic [PW-1:0] p);
    data[s][tail[s]] = p;
    tail[s]++;
    src_empty[s] = 1'b0;
  endtask

  function automatic logic [PW-1:0] mk(input int s, input int n);
    return {8'(s), 28'(n)};
  endfunction

  // One clock: at the falling edge, observe DUT outputs and answer as sources/sink
  task automatic cycle();
    @(negedge clk);
    src_read_gnt   = '0;
    sink_write_gnt = 1'b0;
    n_cmp++;
    if (!$onehot0(src_read_req) || (sink_write_req && src_read_req != '0)) begin
      n_bad++;
      $display("FAIL req_exclusive: src_read_req=%h sink_write_req=%b, required one-hot0 and not during write",
               src_read_req, sink_write_req);
    end
    if (spur && src_read_req != '0 && rd_wait == 2) begin
      src_read_gnt[2]      = 1'b1;
      src_packet[2*PW +: PW] = 36'hB_AD0B_AD00;
      spur = 1'b0;
    end
    if (src_read_req != '0) rd_hi++;
    for (int s = 0; s < NS; s++) begin
      if (src_read_req[s]) begin
        if (rd_wait >= rd_delay) begin
          src_read_gnt[s]      = 1'b1;
          src_packet[s*PW +: PW] = data[s][head[s]];
          head[s]++;
          src_empty[s] = (head[s] == tail[s]);
          rd_wait = 0;
        end else begin
          rd_wait++;
        end
      end
    end
    if (sink_write_req) begin
      wr_hi++;
      n_cmp++;
      if (exp_q.size() == 0 || sink_packet !== exp_q[0]) begin
        n_bad++;
        $display("FAIL sink_packet: got %h, required %h (pending %0d)", sink_packet,
                 (exp_q.size() != 0) ? exp_q[0] : '0, exp_q.size());
      end
      if (wr_wait >= wr_delay) begin
        sink_write_gnt = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        model_cnt++;
        wr_wait = 0;
      end else begin
        wr_wait++;
      end
    end
  endtask

  task automatic drain(input int max, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (n >= max) begin
      n_bad++;
      $display("FAIL %s drain_timeout: %0d packets left, required 0", tag, exp_q.size());
    end
    n_cmp++;
    if (pkt_count !== CW'(model_cnt % (1 << CW))) begin
      n_bad++;
      $display("FAIL %s pkt_count: got %0d, required %0d", tag, pkt_count,
               model_cnt % (1 << CW));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    src_read_gnt   = '0;
    sink_write_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    rd_wait = 0;
    wr_wait = 0;
  endtask

  task automatic test_reset();
    int n;
    // Power-on reset values
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({src_read_req, sink_write_req, sink_packet, cur_src, busy, pkt_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: req=%h wreq=%b pkt=%h cur=%0d busy=%b cnt=%0d, required all 0",
               src_read_req, sink_write_req, sink_packet, cur_src, busy, pkt_count);
    end
    @(negedge clk);
    rst = 1'b1;
    // One good transfer so the counter is non-zero
    load(6, mk(6, 1));
    exp_q.push_back(mk(6, 1));
    drain(20, "reset_pre");
    // Stall in WRITE, then reset asynchronously mid-cycle
    wr_delay = 1000;
    load(6, mk(6, 2));
    exp_q.push_back(mk(6, 2));
    n = 0;
    while (!sink_write_req && n < 10) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (sink_write_req !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_reach_write: sink_write_req=%b, required 1", sink_write_req);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (sink_write_req !== 1'b0 || src_read_req !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: wreq=%b req=%h busy=%b, required 0/0/0",
               sink_write_req, src_read_req, busy);
    end
    n_cmp++;
    if (pkt_count !== '0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d, required 0", pkt_count);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_cnt = 0;
    wr_delay = 0;
    wr_wait = 0;
    // Restart cleanly from IDLE
    load(6, mk(6, 3));
    exp_q.push_back(mk(6, 3));
    drain(20, "reset_restart");
  endtask

  task automatic test_single();
    do_reset();
    load(3, 36'h0_DEAD_BEEF);
    exp_q.push_back(36'h0_DEAD_BEEF);
    cycle();
    n_cmp++;
    if (src_read_req !== 20'h00008) begin
      n_bad++;
      $display("FAIL single_read_req: got %h, required 00008", src_read_req);
    end
    cycle();
    n_cmp++;
    if (sink_write_req !== 1'b1 || sink_packet !== 36'h0_DEAD_BEEF || src_read_req !== '0) begin
      n_bad++;
      $display("FAIL single_write: wreq=%b pkt=%h req=%h, required 1/0DEADBEEF/0",
               sink_write_req, sink_packet, src_read_req);
    end
    cycle();
    n_cmp++;
    if (sink_write_req !== 1'b0 || busy !== 1'b0 || pkt_count !== 4'd1) begin
      n_bad++;
      $display("FAIL single_done: wreq=%b busy=%b cnt=%0d, required 0/0/1",
               sink_write_req, busy, pkt_count);
    end
  endtask

  task automatic test_order();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      load(0, mk(0, n));
      load(5, mk(5, n));
      load(19, mk(19, n));
    end
`ifdef NOC_ARB_ROUND_ROBIN_EN
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(mk(0, n));
      exp_q.push_back(mk(5, n));
      exp_q.push_back(mk(19, n));
    end
`else
    for (int n = 0; n < 2; n++) exp_q.push_back(mk(0, n));
    for (int n = 0; n < 2; n++) exp_q.push_back(mk(5, n));
    for (int n = 0; n < 2; n++) exp_q.push_back(mk(19, n));
`endif
    drain(60, "order");
    n_cmp++;
    if (pkt_count !== 4'd6) begin
      n_bad++;
      $display("FAIL order_count: got %0d, required 6", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    sink_full = 1'b1;
    load(4, mk(4, 1));
    exp_q.push_back(mk(4, 1));
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_cmp++;
      if (src_read_req !== '0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_full: req=%h busy=%b, required 0/0", src_read_req, busy);
      end
    end
    sink_full = 1'b0;
    drain(20, "bp_release");
    wr_delay = 4;
    wr_hi = 0;
    load(1, mk(1, 1));
    load(1, mk(1, 2));
    exp_q.push_back(mk(1, 1));
    exp_q.push_back(mk(1, 2));
    drain(40, "bp_slow_sink");
    n_cmp++;
    if (wr_hi != 10) begin
      n_bad++;
      $display("FAIL bp_write_hold: write req cycles %0d, required 10", wr_hi);
    end
    wr_delay = 0;
  endtask

  task automatic test_delayed_grant();
    rd_delay = 5;
    rd_hi = 0;
    spur = 1'b1;
    load(7, mk(7, 1));
    exp_q.push_back(mk(7, 1));
    drain(30, "delayed_grant");
    n_cmp++;
    if (rd_hi != 6) begin
      n_bad++;
      $display("FAIL delayed_read_hold: read req cycles %0d, required 6", rd_hi);
    end
    rd_delay = 0;
    spur = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 17; n++) begin
      load(9, mk(9, n));
      exp_q.push_back(mk(9, n));
    end
    drain(100, "wrap");
    n_cmp++;
    if (pkt_count !== 4'd1) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d, required 1", pkt_count);
    end
  endtask

  initial begin
    src_empty      = '1;
    src_read_gnt   = '0;
    src_packet     = '0;
    sink_full      = 1'b0;
    sink_write_gnt = 1'b0;
    for (int s = 0; s < NS; s++) begin
      head[s] = 0;
      tail[s] = 0;
    end
    test_reset();
    test_single();
    test_order();
    test_backpressure();
    test_delayed_grant();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
